wb_retire_buffer: RTL

- Parametrised successor to the single-entry writeback stage.
- Sits between MEM and the register file.
- Accepts completed instructions one per cycle through a valid/ready handshake and holds them in an in-order circular buffer of DEPTH entries.
- Retires up to WPORTS entries per cycle to WPORTS register-file write ports, serves NREAD ID-stage forwarding lookups from pending entries, and keeps a retired-instruction counter.

---
 rtl/wb_retire_buffer_if.sv | 55 +++++
 rtl/wb_retire_buffer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_retire_buffer_if.sv
// -----------------------------------------------------------------------------
// wb_retire_buffer_if
// Bundles every non-clock/reset signal of the retire buffer.
//   master : producer side (MEM stage / register file / ID lookups) drives
//            the *_i signals and observes the *_o signals.
//   slave  : the retire buffer itself.
// Signal groups:
//   in_*     enqueue handshake and entry payload
//   rf_*     register-file write ports, one slot per retire lane
//   commit_* per-slot retire strobe and PC
//   fwd_*    ID-stage forwarding lookups
//   count_o / retired_o  occupancy and lifetime retire counter
// -----------------------------------------------------------------------------
interface wb_retire_buffer_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 4,
  parameter int WPORTS = 2,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                       in_valid_i;
  logic                       in_ready_o;
  logic                       in_we_i;
  logic [AW-1:0]              in_dest_i;
  logic [DATA_W-1:0]          in_data_i;
  logic [DATA_W-1:0]          in_pc_i;
  logic                       rf_wready_i;
  logic [WPORTS-1:0]          commit_valid_o;
  logic [WPORTS-1:0]          rf_we_o;
  logic [WPORTS*AW-1:0]       rf_wdest_o;
  logic [WPORTS*DATA_W-1:0]   rf_wdata_o;
  logic [WPORTS*DATA_W-1:0]   commit_pc_o;
  logic [NREAD*AW-1:0]        fwd_raddr_i;
  logic [NREAD-1:0]           fwd_hit_o;
  logic [NREAD*DATA_W-1:0]    fwd_data_o;
  logic [CW-1:0]              count_o;
  logic [CNT_W-1:0]           retired_o;

  modport master (
    output in_valid_i, in_we_i, in_dest_i, in_data_i, in_pc_i,
    output rf_wready_i, fwd_raddr_i,
    input  in_ready_o, commit_valid_o, rf_we_o, rf_wdest_o, rf_wdata_o,
    input  commit_pc_o, fwd_hit_o, fwd_data_o, count_o, retired_o
  );

  modport slave (
    input  in_valid_i, in_we_i, in_dest_i, in_data_i, in_pc_i,
    input  rf_wready_i, fwd_raddr_i,
    output in_ready_o, commit_valid_o, rf_we_o, rf_wdest_o, rf_wdata_o,
    output commit_pc_o, fwd_hit_o, fwd_data_o, count_o, retired_o
  );
endinterface

// File: rtl/wb_retire_buffer.sv
// -----------------------------------------------------------------------------
// wb_retire_buffer
// In-order circular writeback buffer between MEM and the register file.
// Accepts one completed instruction per cycle, retires up to WPORTS oldest
// entries per cycle when the register file is ready, answers NREAD
// forwarding lookups from pending entries and counts retired instructions.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  wb_retire_buffer_if.slave (handshake, write ports, lookups, counters)
// -----------------------------------------------------------------------------
module wb_retire_buffer #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 4,
  parameter int WPORTS = 2,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_retire_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Entry storage (contents are don't-care until written)
  logic              r_we   [DEPTH];
  logic [AW-1:0]     r_dest [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] r_pc   [DEPTH];

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [CNT_W-1:0]  r_retired;

  logic                     w_ready;
  logic                     w_enq;
  logic [CW-1:0]            w_n;
  logic [WPORTS-1:0]        w_valid;
  logic [WPORTS-1:0]        w_we_raw;
  logic [WPORTS-1:0]        w_we;
  logic [WPORTS*AW-1:0]     w_wdest;
  logic [WPORTS*DATA_W-1:0] w_wdata;
  logic [WPORTS*DATA_W-1:0] w_wpc;
  logic [NREAD-1:0]         w_hit;
  logic [NREAD*DATA_W-1:0]  w_fdata;

  // Ready comes only from the registered count, so a full buffer stays
  // closed even in a cycle where it also drains.
  assign w_ready = (r_count < CW'(DEPTH));
  assign w_enq   = bus.in_valid_i & w_ready;

  // Number of entries retiring this cycle: min(count, WPORTS) when RF ready
  always_comb begin
    if (!bus.rf_wready_i) begin
      w_n = '0;
    end else if (r_count > CW'(WPORTS)) begin
      w_n = CW'(WPORTS);
    end else begin
      w_n = r_count;
    end
  end

  // Present the oldest entries on the retire slots; idle slots read as zero
  always_comb begin : slot_sel
    logic [PW-1:0] v_idx;
    w_valid  = '0;
    w_we_raw = '0;
    w_wdest  = '0;
    w_wdata  = '0;
    w_wpc    = '0;
    v_idx    = '0;
    for (int k = 0; k < WPORTS; k++) begin
      v_idx = r_head + PW'(k);
      if (k < int'(w_n)) begin
        w_valid[k]                 = 1'b1;
        w_we_raw[k]                = r_we[v_idx] && (r_dest[v_idx] != '0);
        w_wdest[k*AW +: AW]        = r_dest[v_idx];
        w_wdata[k*DATA_W +: DATA_W] = r_data[v_idx];
        w_wpc[k*DATA_W +: DATA_W]   = r_pc[v_idx];
      end else begin
        w_valid[k]  = 1'b0;
        w_we_raw[k] = 1'b0;
      end
    end
  end

  // Same-cycle WAW: drop an older slot's write if a younger slot writes the
  // same register. w_we_raw already excludes idle slots and x0.
  always_comb begin
    w_we = w_we_raw;
    for (int k = 0; k < WPORTS; k++) begin
      for (int j = k + 1; j < WPORTS; j++) begin
        if (w_we_raw[j] && (w_wdest[j*AW +: AW] == w_wdest[k*AW +: AW])) begin
          w_we[k] = 1'b0;
        end else begin
          w_we[k] = w_we[k];
        end
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match is kept.
  // Entries retiring this cycle are still occupied and take part.
  always_comb begin : fwd_search
    logic [AW-1:0] v_raddr;
    logic [PW-1:0] v_idx;
    w_hit   = '0;
    w_fdata = '0;
    v_raddr = '0;
    v_idx   = '0;
    for (int r = 0; r < NREAD; r++) begin
      v_raddr = bus.fwd_raddr_i[r*AW +: AW];
      for (int i = 0; i < DEPTH; i++) begin
        v_idx = r_head + PW'(i);
        if ((v_raddr != '0) && (i < int'(r_count)) &&
            r_we[v_idx] && (r_dest[v_idx] == v_raddr)) begin
          w_hit[r]                    = 1'b1;
          w_fdata[r*DATA_W +: DATA_W] = r_data[v_idx];
        end else begin
          w_hit[r] = w_hit[r];
        end
      end
    end
  end

  // Entry payload write at tail; no reset needed for storage
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_we[r_tail]   <= bus.in_we_i;
      r_dest[r_tail] <= bus.in_dest_i;
      r_data[r_tail] <= bus.in_data_i;
      r_pc[r_tail]   <= bus.in_pc_i;
    end
  end

  // Pointers, occupancy and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_retired <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      // DEPTH is a power of two, so truncating n wraps head modulo DEPTH
      r_head    <= r_head + PW'(w_n);
      r_count   <= r_count + CW'(w_enq) - w_n;
      r_retired <= r_retired + CNT_W'(w_n);
    end
  end

  assign bus.in_ready_o     = w_ready;
  assign bus.commit_valid_o = w_valid;
  assign bus.rf_we_o        = w_we;
  assign bus.rf_wdest_o     = w_wdest;
  assign bus.rf_wdata_o     = w_wdata;
  assign bus.commit_pc_o    = w_wpc;
  assign bus.fwd_hit_o      = w_hit;
  assign bus.fwd_data_o     = w_fdata;
  assign bus.count_o        = r_count;
  assign bus.retired_o      = r_retired;
endmodule
